// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding and nibble width.
package nibble_serial_subtractor_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cla4.sv
// 4-bit carry-look-ahead adder; the single arithmetic element of the subtractor datapath.
module nibble_serial_subtractor_cla4
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is expanded directly from generate/propagate terms, no ripple.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial unsigned/signed subtractor: diff = a - b - bin, one nibble per clock,
// valid/ready handshakes on both sides, one operation in flight at a time.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic [KW-1:0]    k_q;
  logic             c_q;
  logic             bout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [NIB_W-1:0] a_nibs [NIB];
  logic [NIB_W-1:0] b_nibs [NIB];
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib_n;
  logic [NIB_W-1:0] sum_nib;
  logic             carry_d;

  // Nibble mux from the captured operands and demux back into the result register.
  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nibs[gi] = a_q[gi*NIB_W +: NIB_W];
      assign b_nibs[gi] = b_q[gi*NIB_W +: NIB_W];
      assign diff_d[gi*NIB_W +: NIB_W] = (k_q == KW'(gi)) ? sum_nib
                                                          : diff_q[gi*NIB_W +: NIB_W];
    end
  endgenerate

  assign a_nib   = a_nibs[k_q];
  assign b_nib_n = ~b_nibs[k_q];

  nibble_serial_subtractor_cla4 u_cla (
    .a    (a_nib),
    .b    (b_nib_n),
    .cin  (c_q),
    .sum  (sum_nib),
    .cout (carry_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      c_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            c_q        <= ~bin;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          diff_q <= diff_d;
          c_q    <= carry_d;
          k_q    <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            // Borrow is the inverted final carry; overflow uses the fresh top nibble.
            bout_q      <= ~carry_d;
            ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_nib[NIB_W-1] != a_q[WIDTH-1]);
            k_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor at WIDTH = 16.
module tb_nibble_serial_subtractor;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  res_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    res_t m;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    m.diff = r[W-1:0];
    m.bout = r[W];
    m.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, performs the input handshake and pushes the expected result.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(model(x, y, bi));
  endtask

  task automatic wait_out(input int max, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < max) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic take(output res_t got);
    got = '{diff: diff, bout: bout, ovf: ovf};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001;
    repeat (3) tick();
    total++;
    if ({in_ready, out_valid, diff, bout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b diff=%h bout=%b ovf=%b exp rdy=1 vld=0 diff=0000 bout=0 ovf=0",
               in_ready, out_valid, diff, bout, ovf);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_capture got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    $display("reset: rdy=%b vld=%b diff=%h", in_ready, out_valid, diff);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{16'h0005, 16'h0000, 16'h8000, 16'h1234};
    logic [W-1:0] vb [4] = '{16'h0003, 16'h0001, 16'h0001, 16'h1234};
    logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    res_t         vx [4] = '{'{16'h0002, 1'b0, 1'b0}, '{16'hFFFF, 1'b1, 1'b0},
                             '{16'h7FFF, 1'b0, 1'b1}, '{16'hFFFF, 1'b1, 1'b0}};
    res_t got, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vc[i], ok);
      wait_out(20, lat, ok);
      total++;
      if (!ok || lat != NIB) begin
        bad++;
        $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, NIB);
        continue;
      end
      take(got);
      exp = sb_q.pop_front();
      total++;
      if (got !== vx[i] || exp !== vx[i]) begin
        bad++;
        $display("FAIL directed_%0d got diff=%h bout=%b ovf=%b exp diff=%h bout=%b ovf=%b",
                 i, got.diff, got.bout, got.ovf, vx[i].diff, vx[i].bout, vx[i].ovf);
      end
      $display("directed %h - %h - %b -> diff=%h bout=%b ovf=%b lat=%0d",
               va[i], vb[i], vc[i], got.diff, got.bout, got.ovf, lat);
    end
  endtask

  task automatic test_backpressure();
    res_t got, exp;
    int   lat;
    bit   ok;
    issue(16'h4321, 16'h1234, 1'b0, ok);
    tick();
    a = 16'hAAAA; b = 16'h5555; bin = 1'b1;
    wait_out(20, lat, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_timeout got=no_out_valid exp=out_valid");
      return;
    end
    exp = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      tick();
      total++;
      if ({diff, bout, ovf} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_%0d got diff=%h bout=%b ovf=%b rdy=%b vld=%b exp diff=%h bout=%b ovf=%b rdy=0 vld=1",
                 i, diff, bout, ovf, in_ready, out_valid, exp.diff, exp.bout, exp.ovf);
      end
    end
    take(got);
    exp = sb_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL bp_result got=%h/%b/%b exp=%h/%b/%b", got.diff, got.bout, got.ovf, exp.diff, exp.bout, exp.ovf);
    end
    $display("backpressure: diff=%h bout=%b ovf=%b", got.diff, got.bout, got.ovf);
  endtask

  task automatic test_reset_mid_busy();
    res_t got, exp;
    int   lat;
    bit   ok;
    issue(16'h1111, 16'h0101, 1'b0, ok);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 16'h0) begin
      bad++;
      $display("FAIL midbusy_reset got vld=%b rdy=%b diff=%h exp vld=0 rdy=1 diff=0000", out_valid, in_ready, diff);
    end
    rst_n = 1'b1;
    sb_q.delete();
    issue(16'h00FF, 16'h0100, 1'b0, ok);
    wait_out(20, lat, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midbusy_timeout got=no_out_valid exp=out_valid");
      return;
    end
    take(got);
    exp = sb_q.pop_front();
    total++;
    if (got !== '{16'hFFFF, 1'b1, 1'b0} || got !== exp) begin
      bad++;
      $display("FAIL midbusy_next got=%h/%b/%b exp=ffff/1/0", got.diff, got.bout, got.ovf);
    end
    $display("reset mid-busy then 00ff-0100: diff=%h bout=%b ovf=%b", got.diff, got.bout, got.ovf);
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int   lat, prev_acc, acc;
    bit   ok;
    prev_acc = -1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (in_ready === 1'b1) begin ok = 1'b1; break; end
        tick();
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL b2b_ready_timeout_%0d got=no_in_ready exp=in_ready", i);
        break;
      end
      a = 16'h1000 * i + 16'h0F0F; b = 16'h0123 * (i + 1); bin = i[0];
      tick();
      acc = cyc;
      sb_q.push_back(model(16'h1000 * i + 16'h0F0F, 16'h0123 * (i + 1), i[0]));
      a = ~a; b = ~b;
      if (prev_acc >= 0) begin
        total++;
        if (acc - prev_acc != NIB + 2) begin
          bad++;
          $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, acc - prev_acc, NIB + 2);
        end
      end
      prev_acc = acc;
      wait_out(20, lat, ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL b2b_out_timeout_%0d got=no_out_valid exp=out_valid", i);
        break;
      end
      take(got);
      exp = sb_q.pop_front();
      total++;
      if (got !== exp || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_result_%0d got=%h/%b/%b rdy=%b vld=%b exp=%h/%b/%b rdy=1 vld=0",
                 i, got.diff, got.bout, got.ovf, in_ready, out_valid, exp.diff, exp.bout, exp.ovf);
      end
      $display("back-to-back %0d: diff=%h bout=%b ovf=%b", i, got.diff, got.bout, got.ovf);
    end
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    res_t got, exp;
    logic [W-1:0] x, y;
    logic bi;
    int   n_bad_before, cycles;
    bit   ok;
    n_bad_before = bad;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      out_ready = 1'b0;
      x = pick(); y = pick(); bi = 1'($urandom_range(0, 1));
      issue(x, y, bi, ok);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 20) begin
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        tick();
        cycles++;
      end
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL rand_timeout_%0d got=no_out_valid exp=out_valid", n);
        break;
      end
      repeat ($urandom_range(0, 2)) tick();
      take(got);
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rand_%0d %h-%h-%b got=%h/%b/%b exp=%h/%b/%b",
                 n, x, y, bi, got.diff, got.bout, got.ovf, exp.diff, exp.bout, exp.ovf);
      end
    end
    $display("random: 1000 operations, new failures=%0d", bad - n_bad_before);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL derive localparam NIB = WIDTH/4, the number of nibble steps per operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-013 bout  output  1  borrow-out, 1 when a < b + bin (unsigned).
REQ-014 ovf  output  1  signed two's-complement overflow of the subtraction.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE, both registered/state-decoded with no combinational path from inputs.
REQ-017 On an edge with IDLE and in_valid = 1, SHALL capture a, b, bin, clear nibble index to 0, and enter BUSY; in_valid = 0 in IDLE keeps IDLE.
REQ-018 In BUSY, each edge SHALL process nibble k (bits 4k+3:4k) as a[k] + ~b[k] + c, where c is the stored carry; the initial carry is ~bin.
REQ-019 Each BUSY edge SHALL store the 4-bit result into diff nibble k, store the nibble carry-out as c, and increment k.
REQ-020 On the edge processing nibble NIB-1, SHALL set bout = ~carry-out, set ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), and enter DONE.
REQ-021 Latency: handshake at edge T gives out_valid = 1 after edge T+NIB; for WIDTH = 16, 4 cycles.
REQ-022 In DONE, diff, bout, and ovf SHALL stay stable until out_valid && out_ready, then the FSM SHALL return to IDLE on that edge.
REQ-023 No overlap: a new operation SHALL NOT be accepted in the same edge as a result handshake; throughput is one operation per NIB+2 cycles minimum.
REQ-024 Inputs a, b, and bin changing during BUSY or DONE SHALL NOT affect the result.
REQ-025 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-026 rst_n = 0 at any edge SHALL force IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0, k = 0, and c = 0, including mid-BUSY and mid-DONE; any in-flight operation is discarded.
REQ-027 An in_valid asserted during reset SHALL NOT be captured; capture can first occur on the first edge with rst_n = 1.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, BUSY=1, DONE=2) and the nibble width constant 4.
REQ-029 Nibble arithmetic SHALL use one instance of the team's 4-bit carry-look-ahead adder (ports a, b, cin, sum, cout), fed with a nibble, the inverted b nibble, and the stored carry.
REQ-030 The sub-module SHALL be the only arithmetic logic; the top level holds the FSM, operand registers, and the nibble mux and demux.

Verification (WIDTH = 16)
REQ-031 a = 0x0005, b = 0x0003, bin = 0 -> diff = 0x0002, bout = 0, ovf = 0, out_valid exactly 4 cycles after the handshake.
REQ-032 a = 0x0000, b = 0x0001, bin = 0 -> diff = 0xFFFF, bout = 1, ovf = 0 (full borrow ripple across all nibbles).
REQ-033 a = 0x8000, b = 0x0001, bin = 0 -> diff = 0x7FFF, bout = 0, ovf = 1; then a = 0x1234, b = 0x1234, bin = 1 -> diff = 0xFFFF, bout = 1, ovf = 0.
REQ-034 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> diff, bout, and ovf stable, in_ready = 0; change a and b mid-BUSY -> result unchanged.
REQ-035 Reset mid-BUSY (rst_n = 0 after 2 nibble steps) -> next edge IDLE, out_valid = 0, diff = 0; the next operation, 0x00FF - 0x0100, gives 0xFFFF with bout = 1.
REQ-036 Random self-checking: at least 1000 operations with random in_valid/out_ready stalls, compared against the reference model {bout, diff} = a - b - bin.
